// File: rtl/fsm_prog_bist.sv
// Table-driven Moore FSM with a run-time programmable transition table and LFSR/MISR self-test.
// Latency: 1 cycle from input to state_o; no backpressure, and writes during BIST are dropped with a cfg_err pulse.
module fsm_prog_bist #(
  parameter int          SW       = 4,
  parameter int          IW       = 4,
  parameter int          NT       = 4,
  parameter int          BIST_LEN = 256,
  parameter logic [15:0] SEED     = 16'hACE1,
  localparam int         XW       = (NT > 1) ? $clog2(NT) : 1,
  localparam int         DW       = 1 + 2*IW + SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] sig_in,
  output logic [SW-1:0] state_o,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_state,
  input  logic [XW-1:0] cfg_idx,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_err,
  input  logic          start_bist,
  input  logic          rst_state,
  output logic          bist_busy,
  output logic          bist_done,
  output logic [15:0]   bist_sig
);

  localparam int NS = 1 << SW;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] mask;
    logic [IW-1:0] match;
    logic [SW-1:0] nxt;
  } entry_t;

  entry_t        tbl [NS][NT];
  entry_t        wr_entry;
  logic [15:0]   lfsr;
  logic [15:0]   cnt;
  logic [IW-1:0] x;
  logic [SW-1:0] nxt_state;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign wr_entry = entry_t'(cfg_data);

  // Scan from the top so the lowest-index matching entry has the final say.
  always_comb begin
    x         = bist_busy ? lfsr[IW-1:0] : sig_in;
    nxt_state = state_o;
    for (int e = NT - 1; e >= 0; e--) begin
      if (tbl[state_o][e].vld &&
          (((x ^ tbl[state_o][e].match) & tbl[state_o][e].mask) == '0))
        nxt_state = tbl[state_o][e].nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++)
        for (int e = 0; e < NT; e++)
          tbl[s][e] <= '0;
    end else if (cfg_we && !bist_busy && (int'(cfg_idx) < NT)) begin
      tbl[cfg_state][cfg_idx] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_o   <= '0;
      cfg_err   <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_sig  <= '0;
      lfsr      <= SEED;
      cnt       <= '0;
    end else begin
      cfg_err <= cfg_we && bist_busy;
      if (rst_state) begin
        state_o   <= '0;
        bist_busy <= 1'b0;
        bist_done <= 1'b0;
        bist_sig  <= '0;
        cnt       <= '0;
        lfsr      <= SEED;
      end else if (start_bist && !bist_busy) begin
        state_o   <= '0;
        lfsr      <= SEED;
        bist_sig  <= SEED;
        cnt       <= '0;
        bist_busy <= 1'b1;
        bist_done <= 1'b0;
      end else if (bist_busy) begin
        state_o  <= nxt_state;
        lfsr     <= lfsr_step(lfsr);
        bist_sig <= lfsr_step(bist_sig) ^ 16'(state_o);
        cnt      <= cnt + 16'd1;
        if (cnt == 16'(BIST_LEN - 1)) begin
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
        end
      end else begin
        state_o <= nxt_state;
      end
    end
  end

endmodule

// File: tb/tb_fsm_prog_bist.sv
// Directed bench for fsm_prog_bist: table model plus LFSR/MISR golden model, expected states queued per cycle.
module tb_fsm_prog_bist;
  localparam int          SW   = 4;
  localparam int          IW   = 4;
  localparam int          NT   = 4;
  localparam int          BL   = 256;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] sig_in;
  logic [SW-1:0] state_o;
  logic          cfg_we;
  logic [SW-1:0] cfg_state;
  logic [1:0]    cfg_idx;
  logic [12:0]   cfg_data;
  logic          cfg_err;
  logic          start_bist;
  logic          rst_state;
  logic          bist_busy;
  logic          bist_done;
  logic [15:0]   bist_sig;

  fsm_prog_bist #(.SW(SW), .IW(IW), .NT(NT), .BIST_LEN(BL), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .state_o(state_o),
    .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start_bist(start_bist), .rst_state(rst_state),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_sig(bist_sig)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic       m_vld   [16][NT];
  logic [3:0] m_mask  [16][NT];
  logic [3:0] m_match [16][NT];
  logic [3:0] m_nxt   [16][NT];
  logic [3:0] mstate;
  logic [3:0] exp_q [$];

  function automatic logic [3:0] m_next(input logic [3:0] s, input logic [3:0] xv);
    for (int e = 0; e < NT; e++)
      if (m_vld[s][e] && (((xv ^ m_match[s][e]) & m_mask[s][e]) == 4'h0))
        return m_nxt[s][e];
    return s;
  endfunction

  function automatic logic [15:0] poly_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 16; s++)
      for (int e = 0; e < NT; e++) begin
        m_vld[s][e] = 1'b0; m_mask[s][e] = '0; m_match[s][e] = '0; m_nxt[s][e] = '0;
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle: expected next state is computed from the table as it stood before any same-cycle write.
  task automatic step_n(input logic [3:0] xv, input string tag);
    sig_in = xv;
    exp_q.push_back(m_next(mstate, xv));
    if (cfg_we) begin
      m_vld[cfg_state][cfg_idx]   = cfg_data[12];
      m_mask[cfg_state][cfg_idx]  = cfg_data[11:8];
      m_match[cfg_state][cfg_idx] = cfg_data[7:4];
      m_nxt[cfg_state][cfg_idx]   = cfg_data[3:0];
    end
    tick();
    mstate = exp_q.pop_front();
    chk(tag, 32'(state_o), 32'(mstate));
  endtask

  task automatic cfg_wr(input logic [3:0] s, input logic [1:0] idx, input logic v,
                        input logic [3:0] mask, input logic [3:0] match, input logic [3:0] nxt,
                        input string tag);
    cfg_state = s; cfg_idx = idx; cfg_data = {v, mask, match, nxt}; cfg_we = 1'b1;
    step_n(sig_in, tag);
    cfg_we = 1'b0;
  endtask

  task automatic do_rst_state(input string tag);
    rst_state = 1'b1;
    tick();
    rst_state = 1'b0;
    mstate = 4'h0;
    chk(tag, {state_o, bist_busy, bist_done, bist_sig}, 32'h0);
  endtask

  // Runs one BIST; wr_at/abort_at/arst_at pick the cycle for a mid-run write, rst_state abort or async reset.
  task automatic run_bist(input int wr_at, input int abort_at, input int arst_at);
    logic [15:0] l, g;
    logic [3:0]  st, nst, ev;
    int          k;
    bit          stop;
    exp_q.delete();
    l = SEED; g = SEED; st = 4'h0;
    for (int i = 0; i < BL; i++) begin
      nst = m_next(st, l[3:0]);
      exp_q.push_back(nst);
      g  = poly_step(g) ^ {12'h0, st};
      l  = poly_step(l);
      st = nst;
    end
    start_bist = 1'b1;
    tick();
    start_bist = 1'b0;
    chk("bist_start", {bist_busy, bist_done, bist_sig, state_o}, {1'b1, 1'b0, SEED, 4'h0});
    k = 0; stop = 0;
    while (bist_busy && k < BL + 4 && !stop) begin
      k++;
      if (k == wr_at) begin
        cfg_state = 4'h3; cfg_idx = 2'd0; cfg_data = {1'b1, 4'h0, 4'h0, 4'h9}; cfg_we = 1'b1;
      end
      if (k == abort_at) rst_state = 1'b1;
      if (k == arst_at) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("arst_outputs", {state_o, cfg_err, bist_busy, bist_done, bist_sig}, 32'h0);
        clear_model();
        mstate = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stop = 1;
      end else begin
        tick();
        cfg_we = 1'b0;
        rst_state = 1'b0;
        if (k == wr_at) chk("wr_busy_err", 32'(cfg_err), 32'h1);
        if (k == wr_at + 1) chk("wr_busy_err_clr", 32'(cfg_err), 32'h0);
        if (k == abort_at) begin
          chk("abort", {state_o, bist_busy, bist_done, bist_sig}, 32'h0);
          mstate = 4'h0;
          stop = 1;
        end else if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          chk("bist_state", 32'(state_o), 32'(ev));
        end
      end
    end
    if (!stop) begin
      chk("bist_len", 32'(k), 32'(BL));
      chk("bist_end", {bist_busy, bist_done, bist_sig}, {1'b0, 1'b1, g});
      mstate = st;
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sig_in = '0; cfg_we = 1'b0; cfg_state = '0; cfg_idx = '0; cfg_data = '0;
    start_bist = 1'b0; rst_state = 1'b0;
    clear_model();
    mstate = 4'h0;
    repeat (3) @(posedge clk);
    #1 chk("reset", {state_o, cfg_err, bist_busy, bist_done, bist_sig}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("after_release", {state_o, cfg_err, bist_busy, bist_done, bist_sig}, 32'h0);

    // Basic programming
    cfg_wr(4'h0, 2'd0, 1'b1, 4'hF, 4'h1, 4'h3, "t1_wr");
    step_n(4'h1, "t1_match");
    do_rst_state("t1_rst_state");
    step_n(4'h2, "t1_nomatch");

    // Priority and masking
    cfg_wr(4'h0, 2'd0, 1'b1, 4'b1000, 4'b1000, 4'h5, "t2_wr0");
    cfg_wr(4'h0, 2'd1, 1'b1, 4'hF, 4'hC, 4'h7, "t2_wr1");
    step_n(4'hC, "t2_prio");
    do_rst_state("t2_rst_a");
    step_n(4'h8, "t2_mask");
    do_rst_state("t2_rst_b");
    step_n(4'h4, "t2_hold");
    cfg_wr(4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0, "t2_inval");
    step_n(4'hC, "t2_idx1");
    do_rst_state("t2_rst_c");

    // Eight-state ring, one don't-care entry per state
    sig_in = 4'h0;
    for (int s = 0; s < 8; s++)
      cfg_wr(4'(s), 2'd0, 1'b1, 4'h0, 4'h0, 4'((s + 1) % 8), "t3_ring_wr");
    run_bist(-1, -1, -1);
    run_bist(-1, -1, -1);
    for (int i = 0; i < 3; i++) step_n(4'(i), "t3_resume");

    // Write attempted mid-run must be dropped
    run_bist(20, -1, -1);
    for (int i = 0; i < 9; i++) step_n(4'hA, "t4_table_kept");

    // Abort and simultaneous start/abort
    run_bist(-1, 100, -1);
    start_bist = 1'b1; rst_state = 1'b1;
    tick();
    start_bist = 1'b0; rst_state = 1'b0;
    mstate = 4'h0;
    chk("t5_start_and_abort", {state_o, bist_busy, bist_done, bist_sig}, 32'h0);
    run_bist(-1, -1, -1);

    // Async reset mid-run wipes the table
    run_bist(-1, -1, 50);
    step_n(4'h0, "t6_empty_a");
    step_n(4'h1, "t6_empty_b");
    step_n(4'hC, "t6_empty_c");
    step_n(4'hF, "t6_empty_d");
    cfg_wr(4'h0, 2'd0, 1'b1, 4'hF, 4'h1, 4'h3, "t6_reprog");
    step_n(4'h1, "t6_after_reprog");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
